// File: rtl/uart_tx_scheduler_pkg.sv
// uart_tx_scheduler_pkg: shared UART transmit state encodings and byte width.
// Provides tx_state_t (bit-level transmitter) and tx_sched_state_t (byte scheduler).
package uart_tx_scheduler_pkg;
    localparam int BYTE_W = 8;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE, GAP} tx_sched_state_t;
endpackage

// File: rtl/uart_tx_scheduler_if.sv
// uart_tx_scheduler_if: requester-side byte handshake plus transmitter start/busy link.
// Signals: req_valid/req_data/req_last in, req_ready/grant out, tx_start/tx_data out,
// tx_busy in, sched_busy/err_timeout status out (directions seen from the scheduler).
// slave = scheduler, master = requesters + transmitter environment.
interface uart_tx_scheduler_if #(parameter int NUM_REQ = 4);
    import uart_tx_scheduler_pkg::*;
    logic [NUM_REQ-1:0]        req_valid;
    logic [BYTE_W*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        grant;
    logic                      tx_start;
    logic [BYTE_W-1:0]         tx_data;
    logic                      tx_busy;
    logic                      sched_busy;
    logic                      err_timeout;
    modport slave (
        input  req_valid, req_data, req_last, tx_busy,
        output req_ready, grant, tx_start, tx_data, sched_busy, err_timeout
    );
    modport master (
        output req_valid, req_data, req_last, tx_busy,
        input  req_ready, grant, tx_start, tx_data, sched_busy, err_timeout
    );
endinterface

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of one request at or after a pointer.
// Ports: req_i request vector, mask_en_i/mask_owner_i restrict to one owner,
// ptr_i priority start index, winner_o one-hot winner (zero when nothing eligible).
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req_i,
    input  logic                 mask_en_i,
    input  logic [$clog2(N)-1:0] mask_owner_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    output logic [N-1:0]         winner_o
);
    logic [N-1:0] cand;
    logic [N-1:0] hi;
    logic [N-1:0] pick;
    assign cand = mask_en_i ? (req_i & (N'(1) << mask_owner_i)) : req_i;
    // Candidates at or above the pointer take priority; otherwise wrap to the bottom.
    assign hi = cand & ~((N'(1) << ptr_i) - N'(1));
    assign pick = (|hi) ? hi : cand;
    // Isolate the lowest set bit.
    assign winner_o = pick & (~pick + N'(1));
endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin sharing of one UART transmitter among NUM_REQ byte requesters.
// Ports: clk, rst (async, active low), bus (uart_tx_scheduler_if.slave) carrying the
// requester handshake, transmitter start/data/busy, sched_busy and sticky err_timeout.
module uart_tx_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int GAP_CYCLES  = 16,
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_tx_scheduler_if.slave   bus
);
    import uart_tx_scheduler_pkg::*;
    localparam int PW = $clog2(NUM_REQ);
    localparam int AW = $clog2(ACK_TIMEOUT) + 1;
    localparam int GW = $clog2(GAP_CYCLES) + 1;
    tx_sched_state_t    state_q, state_d;
    logic [PW-1:0]      ptr_q, ptr_d, owner_q, owner_d, owner_nxt, win_idx;
    logic               lock_q, lock_d, last_q, last_d, err_q, err_d;
    logic [NUM_REQ-1:0] grant_q, grant_d, win;
    logic [7:0]         data_q, data_d, win_byte;
    logic [AW-1:0]      ack_q, ack_d;
    logic [GW-1:0]      gap_q, gap_d;
    logic               win_last, msg_end;
    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req_i        (bus.req_valid),
        .mask_en_i    (lock_q),
        .mask_owner_i (owner_q),
        .ptr_i        (ptr_q),
        .winner_o     (win)
    );
    always_comb begin
        win_idx  = '0;
        win_byte = '0;
        win_last = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win[i]) begin
                win_idx  = PW'(i);
                win_byte = bus.req_data[8*i +: 8];
                win_last = bus.req_last[i];
            end
        end
    end
    assign owner_nxt = (owner_q == PW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        lock_d  = lock_q;
        last_d  = last_q;
        err_d   = err_q;
        grant_d = grant_q;
        data_d  = data_q;
        ack_d   = ack_q;
        gap_d   = gap_q;
        msg_end = 1'b0;
        case (state_q)
            IDLE: if (|win) begin
                state_d = ISSUE;
                data_d  = win_byte;
                last_d  = win_last;
                grant_d = win;
                owner_d = win_idx;
            end
            ISSUE: begin
                state_d = WAIT_ACK;
                ack_d   = '0;
            end
            WAIT_ACK: if (bus.tx_busy) begin
                state_d = WAIT_DONE;
            end else begin
                ack_d = ack_q + 1'b1;
                // Abandon the byte and any message in progress.
                if (ack_d >= AW'(ACK_TIMEOUT - 1)) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                    lock_d  = 1'b0;
                    grant_d = '0;
                    ptr_d   = owner_nxt;
                end
            end
            WAIT_DONE: if (!bus.tx_busy) begin
                if (GAP_CYCLES == 0) begin
                    msg_end = 1'b1;
                end else begin
                    state_d = GAP;
                    gap_d   = '0;
                end
            end
            GAP: if (gap_q == GW'(GAP_CYCLES - 1)) msg_end = 1'b1;
                 else gap_d = gap_q + 1'b1;
            default: state_d = IDLE;
        endcase
        // Non-final bytes keep the grant and lock the arbiter to the same owner.
        if (msg_end) begin
            state_d = IDLE;
            lock_d  = !last_q;
            ptr_d   = last_q ? owner_nxt : ptr_q;
            grant_d = last_q ? '0 : grant_q;
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            lock_q  <= 1'b0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
            grant_q <= '0;
            data_q  <= '0;
            ack_q   <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            lock_q  <= lock_d;
            last_q  <= last_d;
            err_q   <= err_d;
            grant_q <= grant_d;
            data_q  <= data_d;
            ack_q   <= ack_d;
            gap_q   <= gap_d;
        end
    end
    assign bus.req_ready   = (state_q == IDLE) ? win : '0;
    assign bus.grant       = grant_q;
    assign bus.tx_start    = (state_q == ISSUE);
    assign bus.tx_data     = data_q;
    assign bus.sched_busy  = (state_q != IDLE) || lock_q;
    assign bus.err_timeout = err_q;
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: directed, table-driven checks of the UART transmit scheduler.
module tb_uart_tx_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;
    uart_tx_scheduler_if #(.NUM_REQ(4)) bus_a ();
    uart_tx_scheduler_if #(.NUM_REQ(4)) bus_b ();
    uart_tx_scheduler #(.NUM_REQ(4), .GAP_CYCLES(16), .ACK_TIMEOUT(8)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a));
    uart_tx_scheduler #(.NUM_REQ(4), .GAP_CYCLES(0), .ACK_TIMEOUT(8)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b));
    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        logic [3:0]  exp_ready;
        logic [7:0]  exp_byte;
    } vec_t;
    vec_t vecs[6];
    int checks = 0;
    int fails  = 0;
    bit model_a = 1'b1;
    bit model_b = 1'b1;
    int busy_len = 10;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask
    // Transmitter models: busy rises the cycle after start and lasts busy_len clocks.
    initial begin
        bus_a.tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (model_a && bus_a.tx_start === 1'b1) begin
                @(negedge clk);
                bus_a.tx_busy = 1'b1;
                repeat (busy_len) @(negedge clk);
                bus_a.tx_busy = 1'b0;
            end
        end
    end
    initial begin
        bus_b.tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (model_b && bus_b.tx_start === 1'b1) begin
                @(negedge clk);
                bus_b.tx_busy = 1'b1;
                repeat (busy_len) @(negedge clk);
                bus_b.tx_busy = 1'b0;
            end
        end
    end
    task automatic wait_start(input bit sel, output int cyc);
        cyc = 0;
        while ((sel ? bus_b.tx_start : bus_a.tx_start) !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 200) begin
            checks++;
            fails++;
            $display("FAIL start_wait: got no tx_start, expected one within 200 clocks");
        end
    endtask
    task automatic wait_idle(input bit sel);
        int n = 0;
        while ((sel ? bus_b.sched_busy : bus_a.sched_busy) !== 1'b0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            checks++;
            fails++;
            $display("FAIL idle_wait: got sched_busy stuck high, expected low within 300 clocks");
        end
    endtask
    task automatic do_reset();
        rst = 1'b0;
        bus_a.req_valid = '0;
        bus_b.req_valid = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask
    initial begin
        int cyc, n;
        bit saw;
        logic [3:0] exp_g[5];
        logic [7:0] exp_d[5];
        #20000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
    initial begin
        int cyc, n;
        bit saw;
        logic [3:0] rr_g[5];
        logic [7:0] rr_d[5];
        vecs[0] = '{4'b0001, 32'h131211A5, 4'b0001, 8'hA5};
        vecs[1] = '{4'b0001, 32'h23222120, 4'b0001, 8'h20};
        vecs[2] = '{4'b1001, 32'h33323130, 4'b1000, 8'h33};
        vecs[3] = '{4'b0110, 32'h43424140, 4'b0010, 8'h41};
        vecs[4] = '{4'b0011, 32'h53525150, 4'b0001, 8'h50};
        vecs[5] = '{4'b1111, 32'h63626160, 4'b0010, 8'h61};
        rr_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rr_d = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
        bus_a.req_valid = '0; bus_a.req_data = '0; bus_a.req_last = '1;
        bus_b.req_valid = '0; bus_b.req_data = '0; bus_b.req_last = '1;
        repeat (2) @(negedge clk);
        check("rst_ready", bus_a.req_ready, 0);
        check("rst_grant", bus_a.grant, 0);
        check("rst_start", bus_a.tx_start, 0);
        check("rst_data", bus_a.tx_data, 0);
        check("rst_sbusy", bus_a.sched_busy, 0);
        check("rst_err", bus_a.err_timeout, 0);
        rst = 1'b1;
        @(negedge clk);
        // Table: single-byte messages, pointer advancing past each served owner.
        for (int i = 0; i < 6; i++) begin
            bus_a.req_valid = vecs[i].valid;
            bus_a.req_data  = vecs[i].data;
            bus_a.req_last  = '1;
            #1;
            check($sformatf("vec%0d_ready", i), bus_a.req_ready, vecs[i].exp_ready);
            @(negedge clk);
            bus_a.req_valid = '0;
            check($sformatf("vec%0d_start", i), bus_a.tx_start, 1);
            check($sformatf("vec%0d_data", i), bus_a.tx_data, vecs[i].exp_byte);
            check($sformatf("vec%0d_grant", i), bus_a.grant, vecs[i].exp_ready);
            check($sformatf("vec%0d_ready_off", i), bus_a.req_ready, 0);
            n = 0;
            while (bus_a.grant !== 4'b0000 && n < 300) begin
                @(negedge clk);
                n++;
            end
            check($sformatf("vec%0d_grant_clear_cycles", i), n, 28);
            check($sformatf("vec%0d_sbusy_end", i), bus_a.sched_busy, 0);
        end
        // Round-robin with all requesters continuously valid.
        do_reset();
        bus_a.req_valid = 4'b1111;
        bus_a.req_data  = 32'h13121110;
        bus_a.req_last  = '1;
        for (int k = 0; k < 5; k++) begin
            wait_start(1'b0, cyc);
            check($sformatf("rr%0d_grant", k), bus_a.grant, rr_g[k]);
            check($sformatf("rr%0d_data", k), bus_a.tx_data, rr_d[k]);
            if (k > 0) check($sformatf("rr%0d_spacing", k), cyc + 1, 29);
            @(negedge clk);
        end
        bus_a.req_valid = '0;
        wait_idle(1'b0);
        // Locked message from requester 1 while 0 and 2 stay valid.
        do_reset();
        bus_a.req_valid = 4'b0001;
        bus_a.req_data  = 32'h00000020;
        bus_a.req_last  = '1;
        wait_start(1'b0, cyc);
        bus_a.req_valid = '0;
        wait_idle(1'b0);
        bus_a.req_valid = 4'b0111;
        bus_a.req_data  = 32'h00220120;
        bus_a.req_last  = 4'b1101;
        wait_start(1'b0, cyc);
        check("lock_b1_grant", bus_a.grant, 4'b0010);
        check("lock_b1_data", bus_a.tx_data, 8'h01);
        bus_a.req_valid = 4'b0101;
        bus_a.req_data  = 32'h00220220;
        bus_a.req_last  = 4'b1111;
        saw = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus_a.tx_start === 1'b1) saw = 1'b1;
        end
        check("lock_hold_nostart", saw, 0);
        check("lock_hold_sbusy", bus_a.sched_busy, 1);
        check("lock_hold_ready", bus_a.req_ready, 0);
        check("lock_hold_grant", bus_a.grant, 4'b0010);
        bus_a.req_valid = 4'b0111;
        wait_start(1'b0, cyc);
        check("lock_b2_grant", bus_a.grant, 4'b0010);
        check("lock_b2_data", bus_a.tx_data, 8'h02);
        bus_a.req_valid = 4'b0101;
        @(negedge clk);
        wait_start(1'b0, cyc);
        check("lock_next_grant", bus_a.grant, 4'b0100);
        check("lock_next_data", bus_a.tx_data, 8'h22);
        bus_a.req_valid = '0;
        wait_idle(1'b0);
        // ACK timeout with the transmitter silent.
        do_reset();
        model_a = 1'b0;
        bus_a.req_valid = 4'b0011;
        bus_a.req_data  = 32'h0000B1B0;
        bus_a.req_last  = '1;
        wait_start(1'b0, cyc);
        check("to_first_grant", bus_a.grant, 4'b0001);
        bus_a.req_valid = 4'b0010;
        n = 0;
        while (bus_a.err_timeout !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("to_err_cycles", n, 8);
        check("to_grant_cleared", bus_a.grant, 0);
        wait_start(1'b0, cyc);
        check("to_next_grant", bus_a.grant, 4'b0010);
        check("to_next_data", bus_a.tx_data, 8'hB1);
        bus_a.req_valid = '0;
        wait_idle(1'b0);
        check("to_err_sticky", bus_a.err_timeout, 1);
        model_a = 1'b1;
        // Asynchronous reset in the middle of a frame.
        do_reset();
        bus_a.req_valid = 4'b0010;
        bus_a.req_data  = 32'h0000C100;
        wait_start(1'b0, cyc);
        bus_a.req_valid = '0;
        wait_idle(1'b0);
        bus_a.req_valid = 4'b0100;
        bus_a.req_data  = 32'h00C20000;
        wait_start(1'b0, cyc);
        bus_a.req_valid = '0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_grant", bus_a.grant, 0);
        check("mid_rst_start", bus_a.tx_start, 0);
        check("mid_rst_data", bus_a.tx_data, 0);
        check("mid_rst_sbusy", bus_a.sched_busy, 0);
        check("mid_rst_ready", bus_a.req_ready, 0);
        repeat (12) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        bus_a.req_valid = 4'b0101;
        bus_a.req_data  = 32'h00D200D0;
        #1;
        check("post_rst_ready", bus_a.req_ready, 4'b0001);
        @(negedge clk);
        bus_a.req_valid = '0;
        check("post_rst_data", bus_a.tx_data, 8'hD0);
        wait_idle(1'b0);
        // Zero gap: back-to-back bytes from requester 0.
        bus_b.req_valid = 4'b0001;
        bus_b.req_data  = 32'h000000A1;
        bus_b.req_last  = '1;
        wait_start(1'b1, cyc);
        check("gap0_b1_data", bus_b.tx_data, 8'hA1);
        bus_b.req_data = 32'h000000A2;
        @(negedge clk);
        wait_start(1'b1, cyc);
        check("gap0_spacing", cyc + 1, 13);
        check("gap0_b2_data", bus_b.tx_data, 8'hA2);
        bus_b.req_valid = '0;
        wait_idle(1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Shares one UART transmitter among `NUM_REQ` byte requesters. The block arbitrates round-robin, hands each accepted byte to the transmitter with a start/busy handshake, and inserts a programmable idle gap between frames. Multi-byte messages are kept contiguous by holding the grant until the requester marks the last byte. It sits between the system-side byte producers and the transmitter/baud unit, and runs entirely in the system clock domain.

## Interface
- `NUM_REQ`, default 4: number of requesters, range 2–8.
- `GAP_CYCLES`, default 16: idle clocks after the transmitter drops busy before the next start. 0 means no gap.
- `ACK_TIMEOUT`, default 1024: clocks to wait for `tx_busy` to rise after `tx_start`.
- `clk`, input, 1: system clock. All logic is on the rising edge.
- `rst`, input, 1: asynchronous, active-low reset. Low means reset.
- `req_valid`, input, NUM_REQ: requester i has a byte. Must be held with its data until accepted.
- `req_data`, input, 8*NUM_REQ: byte for requester i, at bits [8i+7:8i].
- `req_last`, input, NUM_REQ: the offered byte ends requester i's message.
- `req_ready`, output, NUM_REQ: one-hot accept. A transfer occurs when valid and ready are both high.
- `grant`, output, NUM_REQ: one-hot current owner, held from accept until the message ends.
- `tx_start`, output, 1: one-cycle start pulse to the transmitter.
- `tx_data`, output, 8: byte for the transmitter. Stable from start until busy falls.
- `tx_busy`, input, 1: the transmitter is sending a frame.
- `sched_busy`, output, 1: high in any state other than IDLE, or while the lock is held.
- `err_timeout`, output, 1: sticky. Set when the ACK timeout expires. Cleared only by reset.

## Operation
- States: IDLE, ISSUE, WAIT_ACK, WAIT_DONE, GAP.
- **IDLE**
  - Candidate set: `req_valid` masked to the locked owner when the lock is set, otherwise all requesters.
  - Winner: the first candidate at or after the round-robin pointer, wrapping.
  - `req_ready[winner]` is driven combinationally in the same cycle.
  - On transfer: latch the data into `tx_data`, latch `req_last`, set `grant`, and go to ISSUE.
  - No candidate: stay in IDLE.
- **ISSUE**: `tx_start` = 1 for exactly one cycle. Clear the ACK counter. Go to WAIT_ACK.
- **WAIT_ACK**
  - `tx_busy` = 1: go to WAIT_DONE.
  - Counter reaches `ACK_TIMEOUT`-1: set `err_timeout`, drop the byte, clear the lock and `grant`, advance the pointer, and go to IDLE.
- **WAIT_DONE**: on `tx_busy` = 0, go to GAP. If `GAP_CYCLES` = 0, go directly to the message-end handling below.
- **GAP**: count `GAP_CYCLES` clocks, then handle message end.
- **Message end**
  - Latched last = 1:
    - Clear the lock and `grant`.
    - Move the pointer to owner+1 modulo `NUM_REQ`.
    - Go to IDLE.
  - Latched last = 0: set the lock, keep `grant`, go to IDLE.
- **Locked owner drops `req_valid`**: the block waits in IDLE indefinitely with the lock held. Other requesters are not served. Only reset releases the lock.
- **Lock lifetime**: a timeout clears the lock; the message is abandoned.
- **`req_data` / `req_last` of non-granted requesters**: ignored.
- **Counter widths**: `$clog2` of the parameter value plus 1. The pointer is `$clog2(NUM_REQ)` bits and wraps explicitly at `NUM_REQ`-1.

## Timing
- **Reset values**:
  - `req_ready` = 0, `grant` = 0, `tx_start` = 0, `tx_data` = 8'h00.
  - `sched_busy` = 0, `err_timeout` = 0.
  - Pointer = 0, lock clear, state = IDLE.
- **Reset mid-frame**: takes effect asynchronously. The in-flight byte is lost. The transmitter is not notified.
- **Latency**: accept in cycle T; `tx_start` high in T+1; earliest recheck of `tx_busy` in T+2.
- **Minimum spacing** between `tx_start` pulses: 2 + busy duration + `GAP_CYCLES` + 1 (the IDLE accept cycle).
- **Simultaneous requests**: the pointer decides the winner. Requests arriving during a frame wait. `req_ready` is never high outside IDLE.
- **`tx_busy` already high in ISSUE** (transmitter still finishing): accepted as ACK in the next cycle. The transmitter must keep busy low before honouring the next start.

## Structure
- Add `tx_sched_state_t` (IDLE, ISSUE, WAIT_ACK, WAIT_DONE, GAP) to the shared states package, alongside the existing transmitter states. Reuse nothing from that enum.
- Sub-module `rr_arbiter`, parameterised by N:
  - Inputs: request vector, mask enable/owner, pointer.
  - Output: one-hot winner.
  - Purely combinational, and reusable for a future receiver dispatcher.
- FSM, counters and output registers live in `uart_tx_scheduler`.

## Test plan
- **Single byte**: req0 valid, data 8'hA5, last = 1; busy model of 10 clocks.
  - `req_ready[0]` goes high in cycle T.
  - `tx_start` pulses in T+1 with `tx_data` = A5.
  - `grant` clears after 16 gap clocks.
- **Round-robin**: all four requesters hold valid with last = 1.
  - Start order is 0,1,2,3,0.
  - Bytes 8'h10..8'h13 appear in that order.
- **Locked message**: req1 sends 8'h01 (last = 0) then 8'h02 (last = 1), while req0 and req2 stay valid throughout.
  - Both req1 bytes go out back-to-back.
  - req2 is served next.
- **Timeout**: `tx_busy` tied low, `ACK_TIMEOUT` = 8.
  - `err_timeout` rises 8 clocks after `tx_start` and stays set.
  - The scheduler returns to IDLE and serves the next requester.
- **Reset mid-frame**: assert `rst` low during WAIT_DONE.
  - All outputs go to their reset values immediately.
  - After release, requester 0 wins first.
- **`GAP_CYCLES` = 0**: two back-to-back bytes. The second `tx_start` comes 2 clocks after busy falls.
